// File: rtl/matrixmult_feeder.sv
// Operand feeder and result collector for the matrixmult core over FSL.
// Optional macro MATRIXMULT_FEEDER_CTRL_MARK_EN marks the last word of each row group on FSL_M_Control.
module matrixmult_feeder #(
  parameter int unsigned ROWS = 4,
  parameter int unsigned COLS = 4
) (
  input  logic        FSL_Clk,
  input  logic        FSL_Rst,
  input  logic        cfg_wr,
  input  logic [4:0]  cfg_addr,
  input  logic [31:0] cfg_data,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] result0,
  output logic [31:0] result1,
  output logic [31:0] result2,
  output logic [31:0] result3,
  output logic        FSL_M_Clk,
  output logic        FSL_M_Write,
  output logic [31:0] FSL_M_Data,
  output logic        FSL_M_Control,
  input  logic        FSL_M_Full,
  output logic        FSL_S_Clk,
  output logic        FSL_S_Read,
  input  logic [31:0] FSL_S_Data,
  input  logic        FSL_S_Control,
  input  logic        FSL_S_Exists
);

  localparam int unsigned NWORDS = 2 * ROWS * COLS;
  localparam int unsigned SW     = $clog2(NWORDS);
  localparam int unsigned KW     = $clog2(ROWS + 1);
  localparam int unsigned MW     = $clog2(ROWS * COLS);
  localparam int unsigned PW     = $clog2(COLS);
  localparam int unsigned RW     = $clog2(ROWS);

  localparam logic [SW-1:0] S_LAST = SW'(NWORDS - 1);
  localparam logic [KW-1:0] K_FULL = KW'(ROWS);
  localparam logic [KW-1:0] K_LAST = KW'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, XFER, DRAIN, FIN} state_t;

  state_t        state;
  logic [SW-1:0] s;
  logic [KW-1:0] k;
  logic          busy_q;
  logic          done_q;
  logic [31:0]   matrix [ROWS*COLS];
  logic [31:0]   pixel  [COLS];
  logic [31:0]   result [ROWS];

  logic          m_write;
  logic          s_read;
  logic [31:0]   word;
  logic [31:0]   grp;
  logic [31:0]   col;
  logic [31:0]   midx;
  logic          unused_ok;

  assign FSL_M_Clk   = FSL_Clk;
  assign FSL_S_Clk   = FSL_Clk;
  assign busy        = busy_q;
  assign done        = done_q;
  assign result0     = result[0];
  assign result1     = result[1];
  assign result2     = result[2];
  assign result3     = result[3];
  assign unused_ok   = FSL_S_Control;

  assign m_write     = (state == XFER) && !FSL_M_Full;
  assign s_read      = busy_q && FSL_S_Exists && (k < K_FULL);
  assign FSL_M_Write = m_write;
  assign FSL_M_Data  = word;
  assign FSL_S_Read  = s_read;

`ifdef MATRIXMULT_FEEDER_CTRL_MARK_EN
  assign FSL_M_Control = ((32'(s) % (2 * COLS)) == (2 * COLS - 1));
`else
  assign FSL_M_Control = 1'b0;
`endif

  // Even words come from the current matrix row, odd words from the pixel vector.
  always_comb begin
    word = '0;
    grp  = 32'(s) / (2 * COLS);
    col  = (32'(s) % (2 * COLS)) / 2;
    midx = grp * COLS + col;
    for (int unsigned i = 0; i < ROWS * COLS; i++) begin
      if (!s[0] && (i == midx)) word = matrix[MW'(i)];
    end
    for (int unsigned j = 0; j < COLS; j++) begin
      if (s[0] && (j == col)) word = pixel[PW'(j)];
    end
  end

  always_ff @(posedge FSL_Clk or negedge FSL_Rst) begin
    if (!FSL_Rst) begin
      state  <= IDLE;
      s      <= '0;
      k      <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      for (int unsigned i = 0; i < ROWS * COLS; i++) matrix[MW'(i)] <= '0;
      for (int unsigned j = 0; j < COLS; j++) pixel[PW'(j)] <= '0;
      for (int unsigned r = 0; r < ROWS; r++) result[RW'(r)] <= '0;
    end else begin
      done_q <= 1'b0;
      if (m_write) s <= s + SW'(1);
      if (s_read) begin
        for (int unsigned r = 0; r < ROWS; r++) begin
          if (32'(k) == r) result[RW'(r)] <= FSL_S_Data;
        end
        k <= k + KW'(1);
      end
      unique case (state)
        IDLE: begin
          if (cfg_wr) begin
            for (int unsigned i = 0; i < ROWS * COLS; i++) begin
              if (32'(cfg_addr) == i) matrix[MW'(i)] <= cfg_data;
            end
            for (int unsigned j = 0; j < COLS; j++) begin
              if (32'(cfg_addr) == ROWS * COLS + j) pixel[PW'(j)] <= cfg_data;
            end
          end
          if (start) begin
            state  <= XFER;
            busy_q <= 1'b1;
            s      <= '0;
            k      <= '0;
            for (int unsigned r = 0; r < ROWS; r++) result[RW'(r)] <= '0;
          end
        end
        XFER: begin
          // A read landing with the final write still counts toward completion.
          if (m_write && (s == S_LAST)) begin
            if ((k == K_FULL) || (s_read && (k == K_LAST))) begin
              state  <= FIN;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (s_read && (k == K_LAST)) begin
            state  <= FIN;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/matrixmult_feeder.md
Name: matrixmult_feeder

Overview:
- FSL-master-side driver for the matrixmult core: holds a 4x4 single-precision matrix and a 4-element pixel vector, streams them out as interleaved operand pairs, and collects the per-row results returned on its FSL slave port.
- Sits between the host register interface and matrixmult, playing the role the bench plays today.
- All data words are IEEE-754 single-precision bit patterns; the block performs no arithmetic on them.

Parameters:
- ROWS, 4, number of matrix rows streamed and results expected.
- COLS, 4, elements per row, equal to the pixel vector length.

Ports:
- FSL_Clk  in  1  single clock, rising edge.
- FSL_Rst  in  1  asynchronous, active-low reset.
- cfg_wr  in  1  host register write strobe.
- cfg_addr  in  5  0..15 selects matrix[r][c] at r*4+c; 16..19 selects pixel[0..3]; 20..31 writes are ignored.
- cfg_data  in  32  host write data.
- start  in  1  one-cycle pulse that begins a transfer.
- busy  out  1  high from start until done.
- done  out  1  one-cycle pulse when all words are sent and all results are received.
- result0..result3  out  32 each  captured results, in arrival order.
- FSL_M_Clk  out  1  tied to FSL_Clk.
- FSL_M_Write  out  1  word valid on FSL_M_Data this cycle.
- FSL_M_Data  out  32  operand word.
- FSL_M_Control  out  1  see Optional Feature.
- FSL_M_Full  in  1  downstream cannot accept a word.
- FSL_S_Clk  out  1  tied to FSL_Clk.
- FSL_S_Read  out  1  consumes FSL_S_Data this cycle.
- FSL_S_Data  in  32  result word.
- FSL_S_Control  in  1  ignored.
- FSL_S_Exists  in  1  result word available.

Behaviour:
- Reset (FSL_Rst low, asynchronous):
  - State goes to IDLE.
  - busy, done, FSL_M_Write, FSL_M_Data, FSL_M_Control and FSL_S_Read are 0.
  - result0..3, matrix and pixel registers are cleared to 0.
  - Reset mid-transfer aborts immediately; no done pulse is produced.
- Config writes:
  - Accepted only in IDLE. cfg_wr while busy is dropped.
- States: IDLE, XFER, DRAIN, FIN.
  - IDLE -> XFER on start. Clears send index s (0..2*ROWS*COLS-1) and receive count k.
  - start while busy is ignored.
- XFER send sequence:
  - Word s is matrix[s/8][(s%8)/2] if s is even, and pixel[(s%8)/2] if s is odd.
  - For ROWS=4 the order is m00, p0, m01, p1, m02, p2, m03, p3, m10, p0, ... (32 words).
- Master handshake:
  - FSL_M_Write = (state==XFER) && !FSL_M_Full, combinational from registered state and index.
  - FSL_M_Data always presents the word at index s.
  - s advances only on a cycle with FSL_M_Write=1.
  - When FSL_M_Full is held, FSL_M_Data holds the same word and no word is skipped or duplicated.
  - Full toggling every cycle still yields exactly 32 writes.
- Slave handshake:
  - FSL_S_Read = busy && FSL_S_Exists && (k < ROWS).
  - On a read, FSL_S_Data is stored into result[k] and k increments.
  - Results may arrive during XFER; the block must never block result intake while it is still sending.
- State exits:
  - XFER -> DRAIN after the write of the last word, if k < ROWS.
  - XFER -> FIN directly if k == ROWS already (this counts a read in the same cycle).
  - DRAIN -> FIN on the read of result ROWS-1.
  - FIN -> IDLE after one cycle. done=1 during FIN; busy=0 from FIN onward.
- Simultaneous events:
  - A last write and a last read in the same cycle go straight to FIN.
  - A start pulse in FIN is ignored.
- Timing:
  - Minimum latency from start to the first FSL_M_Write is 1 cycle.
  - With no back-pressure, 32 sends take 32 consecutive cycles.
- results hold their values until the next start, which clears them to 0.

Optional Feature:
- Macro: MATRIXMULT_FEEDER_CTRL_MARK_EN.
- Defined: FSL_M_Control=1 with the last word of each row group (s%8==7, the p3 word) and 0 otherwise. It is qualified like FSL_M_Data.
- Undefined: FSL_M_Control is constant 0 and no extra logic is generated.

Test Plan:
- Basic stream:
  - Stimulus: load the matrix (row0 = 4124CCCD, 40C80000, 40A9999A, 3C4CCCCD; row1 = 40600000, 40980000, 4111999A, 43164CCD; row2 = BF07AE14, 4141999A, C1691EB8, 4040A3D7; row3 = 3C4CCCCD, 40A9999A, 40C80000, 4124CCCD) and pixel = BF07AE14, 4141999A, C1691EB8, 4040A3D7. Pulse start with FSL_M_Full=0.
  - Required: 32 consecutive writes in the interleaved order; word1 = BF07AE14, word8 = 40600000.
- Loopback with the matrixmult core:
  - Required: result0..3 = C0E08E56, 43BBB7CF, 43B80498, 4082161E; done pulses exactly once; busy falls the same cycle.
- Back-pressure:
  - Stimulus: FSL_M_Full driven with a pseudo-random 50% pattern.
  - Required: exactly 32 writes, same data order, and FSL_M_Data stable across every full cycle.
- Early results:
  - Stimulus: the model returns each result as soon as its row is sent, including one on the same cycle as the final write.
  - Required: FSL_S_Read accepts each result immediately; the FSM goes XFER -> FIN with no DRAIN cycle.
- Reset and ignored inputs:
  - Stimulus: assert FSL_Rst low at word 13; then send cfg_wr and start while busy.
  - Required: all outputs are 0 asynchronously and no done pulse occurs; the writes and start issued while busy are ignored, verified by matrix contents and FSM state.
- Control marker (MATRIXMULT_FEEDER_CTRL_MARK_EN defined):
  - Required: FSL_M_Control=1 exactly on words 7, 15, 23 and 31.
  - Repeat with the macro undefined: FSL_M_Control is always 0.
